// File: rtl/mult_fsm.sv
// Shift-free multiplier sequencer: drives an external register-file datapath
// through a repeated-add loop and writes the 16-bit product to REG_OUT.
module mult_fsm #(
  parameter int REG_A   = 6,
  parameter int REG_CNT = 7,
  parameter int REG_P   = 8,
  parameter int REG_I   = 9,
  parameter int REG_OUT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [4:0]  Flags_out,
  output logic [15:0] wEnable,
  output logic [15:0] Imm_in,
  output logic [7:0]  opcode,
  output logic [3:0]  Rdest_sel,
  output logic [3:0]  Rsrc_sel,
  output logic        Imm_sel,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADDU  = 8'b0000_0110;
  localparam logic [7:0] OP_ADDUI = 8'b0110_0000;
  localparam logic [7:0] OP_CMP   = 8'b0000_1011;
  localparam logic [7:0] OP_MOVI  = 8'b1101_0000;

  localparam logic [15:0] WE_A   = 16'(1) << REG_A;
  localparam logic [15:0] WE_CNT = 16'(1) << REG_CNT;
  localparam logic [15:0] WE_P   = 16'(1) << REG_P;
  localparam logic [15:0] WE_I   = 16'(1) << REG_I;
  localparam logic [15:0] WE_OUT = 16'(1) << REG_OUT;

  localparam logic [3:0] SEL_A   = 4'(REG_A);
  localparam logic [3:0] SEL_CNT = 4'(REG_CNT);
  localparam logic [3:0] SEL_P   = 4'(REG_P);
  localparam logic [3:0] SEL_I   = 4'(REG_I);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_C, CLR_P, CLR_I,
    CHECK, ADD, INC, WRITE_OUT, DONE
  } state_t;

  state_t state, next;
  logic [15:0] mult_q, cnt_q;

  logic unused_flags;
  assign unused_flags = ^Flags_out[3:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mult_q <= '0;
      cnt_q  <= '0;
    end else begin
      state <= next;
      // Smaller operand becomes the loop count to minimise iterations
      if (state == IDLE && start) begin
        mult_q <= (op_a >= op_b) ? op_a : op_b;
        cnt_q  <= (op_a >= op_b) ? op_b : op_a;
      end
    end
  end

  always_comb begin
    next      = state;
    wEnable   = '0;
    Imm_in    = '0;
    opcode    = OP_NOP;
    Rdest_sel = '0;
    Rsrc_sel  = '0;
    Imm_sel   = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next = LOAD_A;
      end
      LOAD_A: begin
        opcode  = OP_MOVI;
        Imm_in  = mult_q;
        Imm_sel = 1'b0;
        wEnable = WE_A;
        next    = LOAD_C;
      end
      LOAD_C: begin
        opcode  = OP_MOVI;
        Imm_in  = cnt_q;
        Imm_sel = 1'b0;
        wEnable = WE_CNT;
        next    = CLR_P;
      end
      CLR_P: begin
        opcode  = OP_MOVI;
        Imm_sel = 1'b0;
        wEnable = WE_P;
        next    = CLR_I;
      end
      CLR_I: begin
        opcode  = OP_MOVI;
        Imm_sel = 1'b0;
        wEnable = WE_I;
        next    = CHECK;
      end
      CHECK: begin
        opcode    = OP_CMP;
        Rdest_sel = SEL_I;
        Rsrc_sel  = SEL_CNT;
        next      = Flags_out[4] ? ADD : WRITE_OUT;
      end
      ADD: begin
        opcode    = OP_ADDU;
        Rdest_sel = SEL_P;
        Rsrc_sel  = SEL_A;
        wEnable   = WE_P;
        next      = INC;
      end
      INC: begin
        opcode    = OP_ADDUI;
        Rdest_sel = SEL_I;
        Imm_in    = 16'd1;
        Imm_sel   = 1'b0;
        wEnable   = WE_I;
        next      = CHECK;
      end
      WRITE_OUT: begin
        opcode    = OP_ADDUI;
        Rdest_sel = SEL_P;
        Imm_sel   = 1'b0;
        wEnable   = WE_OUT;
        next      = DONE;
      end
      DONE: begin
        done = 1'b1;
        next = IDLE;
      end
      default: begin
        busy = 1'b0;
        next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_fsm.sv
// Bench for mult_fsm: register-file datapath model, directed and random
// multiplies checked against plain arithmetic and the latency formula.
module tb_mult_fsm;

  localparam logic [7:0] NOP   = 8'h00;
  localparam logic [7:0] ADDU  = 8'b0000_0110;
  localparam logic [7:0] ADDUI = 8'b0110_0000;
  localparam logic [7:0] CMP   = 8'b0000_1011;
  localparam logic [7:0] MOVI  = 8'b1101_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [4:0]  Flags_out;
  logic [15:0] wEnable, Imm_in;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_sel, Rsrc_sel;
  logic        Imm_sel, busy, done;

  int checks = 0;
  int failures = 0;
  int inv_viol = 0;
  int out_writes = 0;
  int all_writes = 0;
  int done_count = 0;
  bit mon_en = 1'b0;

  logic [15:0] regs [16];

  mult_fsm dut (
    .clk(clk), .reset(reset), .start(start),
    .op_a(op_a), .op_b(op_b), .Flags_out(Flags_out),
    .wEnable(wEnable), .Imm_in(Imm_in), .opcode(opcode),
    .Rdest_sel(Rdest_sel), .Rsrc_sel(Rsrc_sel),
    .Imm_sel(Imm_sel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Datapath model: compare flag and register writes
  always_comb begin
    Flags_out = 5'b0;
    if (opcode == CMP && regs[Rdest_sel] < regs[Rsrc_sel])
      Flags_out[4] = 1'b1;
  end

  always @(posedge clk) begin
    logic [15:0] opb, res;
    opb = Imm_sel ? regs[Rsrc_sel] : Imm_in;
    res = 16'h0;
    if (opcode == MOVI) res = Imm_in;
    else if (opcode == ADDU || opcode == ADDUI) res = regs[Rdest_sel] + opb;
    for (int i = 0; i < 16; i++)
      if (wEnable[i]) regs[i] <= res;
    if (wEnable != 0) all_writes++;
    if (wEnable[5]) out_writes++;
    if (done) done_count++;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if ($countones(wEnable) > 1) begin
        inv_viol++;
        $display("FAIL onehot wEnable got=%h need<=1 bit", wEnable);
      end
      if (!busy && (wEnable != 0 || opcode != NOP || Imm_in != 0 ||
          Rdest_sel != 0 || Rsrc_sel != 0 || Imm_sel != 1'b1 || done)) begin
        inv_viol++;
        $display("FAIL idle_defaults we=%h op=%h imm=%h done=%b", wEnable, opcode, Imm_in, done);
      end
    end
  end

  function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
    return 7 + 3 * int'((a < b) ? a : b);
  endfunction

  function automatic logic [15:0] exp_prod(input logic [15:0] a, input logic [15:0] b);
    return 16'(32'(a) * 32'(b));
  endfunction

  // Starts an op from IDLE and waits (bounded) for done
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic [15:0] ia,
                       output logic [15:0] ic, output bit to);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom);
    lat = 0; ia = '0; ic = '0; to = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (n == 1) ia = Imm_in;
      if (n == 2) ic = Imm_in;
      if (done) begin lat = n; to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op_a = 16'd7; op_b = 16'd9;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wEnable !== 16'h0 || opcode !== NOP ||
        Imm_in !== 16'h0 || Imm_sel !== 1'b1 || Rdest_sel !== 4'h0 || Rsrc_sel !== 4'h0) begin
      failures++;
      $display("FAIL reset_defaults busy=%b done=%b we=%h op=%h imm=%h sel=%b need 0/0/0/0/0/1",
               busy, done, wEnable, opcode, Imm_in, Imm_sel);
    end
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || all_writes != 0) begin
      failures++;
      $display("FAIL reset_idle busy=%b writes=%0d need 0/0", busy, all_writes);
    end
  endtask

  task automatic test_directed();
    logic [15:0] a [3] = '{16'd3, 16'd0, 16'd300};
    logic [15:0] b [3] = '{16'd4, 16'd5, 16'd300};
    logic [15:0] er [3] = '{16'd12, 16'd0, 16'd24464};
    int el [3] = '{16, 7, 907};
    logic [15:0] ea [3] = '{16'd4, 16'd5, 16'd300};
    logic [15:0] ec [3] = '{16'd3, 16'd0, 16'd300};
    int lat; logic [15:0] ia, ic; bit to;
    for (int i = 0; i < 3; i++) begin
      do_op(a[i], b[i], lat, ia, ic, to);
      checks++;
      if (to || lat != el[i]) begin
        failures++;
        $display("FAIL dir%0d_latency got=%0d need=%0d timeout=%b", i, lat, el[i], to);
      end
      checks++;
      if (regs[5] !== er[i]) begin
        failures++;
        $display("FAIL dir%0d_result got=%0d need=%0d", i, regs[5], er[i]);
      end
      checks++;
      if (ia !== ea[i] || ic !== ec[i]) begin
        failures++;
        $display("FAIL dir%0d_capture mult=%0d cnt=%0d need %0d/%0d", i, ia, ic, ea[i], ec[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat = 0; int drops = 0; bit saw_add = 1'b0; int idle_busy = 0;
    @(negedge clk);
    start = 1'b1; op_a = 16'd9; op_b = 16'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (!busy) drops++;
      if (n == 6) begin
        saw_add = (opcode == ADDU);
        start = 1'b1; op_a = 16'd2; op_b = 16'd3;
      end
      if (n == 7) start = 1'b0;
      if (done) begin lat = n; break; end
    end
    checks++;
    if (!saw_add) begin
      failures++;
      $display("FAIL ignore_in_add opcode=%h need=%h", opcode, ADDU);
    end
    checks++;
    if (drops != 0) begin
      failures++;
      $display("FAIL ignore_busy_drop got=%0d need=0", drops);
    end
    checks++;
    if (lat != exp_lat(16'd9, 16'd9) || regs[5] !== 16'd81) begin
      failures++;
      $display("FAIL ignore_result lat=%0d res=%0d need %0d/81", lat, regs[5], exp_lat(16'd9, 16'd9));
    end
    repeat (3) begin
      @(negedge clk);
      if (busy) idle_busy++;
    end
    checks++;
    if (idle_busy != 0) begin
      failures++;
      $display("FAIL ignore_no_restart busy_cycles=%0d need=0", idle_busy);
    end
  endtask

  task automatic test_reset_mid();
    int ow, dc, aw, busy_cnt = 0;
    logic [15:0] r5;
    bit in_inc = 1'b0;
    ow = out_writes; dc = done_count; r5 = regs[5];
    @(negedge clk);
    start = 1'b1; op_a = 16'd5; op_b = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 10; n++) @(negedge clk);
    in_inc = (opcode == ADDUI && wEnable == 16'h0200);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (!in_inc) begin
      failures++;
      $display("FAIL rst_mid_inc op=%h we=%h need %h/0200", opcode, wEnable, ADDUI);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wEnable !== 16'h0 || opcode !== NOP || Imm_in !== 16'h0) begin
      failures++;
      $display("FAIL rst_mid_defaults busy=%b done=%b we=%h op=%h imm=%h need 0", busy, done, wEnable, opcode, Imm_in);
    end
    reset = 1'b0;
    aw = all_writes;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    checks++;
    if (out_writes != ow || done_count != dc || regs[5] !== r5) begin
      failures++;
      $display("FAIL rst_mid_abandon outw=%0d done=%0d r5=%0d need %0d/%0d/%0d",
               out_writes, done_count, regs[5], ow, dc, r5);
    end
    checks++;
    if (all_writes != aw || busy_cnt != 0) begin
      failures++;
      $display("FAIL rst_mid_quiet writes=%0d busy=%0d need %0d/0", all_writes, busy_cnt, aw);
    end
  endtask

  task automatic test_back_to_back();
    int lat1 = 0, lat2 = 0;
    logic [15:0] r1 = '0;
    bit gap, restarted;
    @(negedge clk);
    start = 1'b1; op_a = 16'd6; op_b = 16'd7;
    @(posedge clk); #1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done) begin lat1 = n; break; end
    end
    r1 = regs[5];
    op_a = 16'd11; op_b = 16'd2;
    @(negedge clk);
    gap = !busy;
    @(negedge clk);
    restarted = busy && opcode == MOVI && Imm_in == 16'd11;
    start = 1'b0;
    for (int n = 2; n <= 200; n++) begin
      @(negedge clk);
      if (done) begin lat2 = n; break; end
    end
    checks++;
    if (lat1 != 25 || r1 !== 16'd42) begin
      failures++;
      $display("FAIL b2b_first lat=%0d res=%0d need 25/42", lat1, r1);
    end
    checks++;
    if (!gap || !restarted) begin
      failures++;
      $display("FAIL b2b_idle_gap gap=%b restart=%b need 1/1", gap, restarted);
    end
    checks++;
    if (lat2 != 13 || regs[5] !== 16'd22) begin
      failures++;
      $display("FAIL b2b_second lat=%0d res=%0d need 13/22", lat2, regs[5]);
    end
  endtask

  task automatic test_random();
    int lat; logic [15:0] ia, ic, a, b, mx, mn; bit to;
    for (int i = 0; i < 25; i++) begin
      a = 16'($urandom);
      b = 16'($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) begin mx = a; a = b; b = mx; end
      if (i == 0) b = a;
      mx = (a > b) ? a : b;
      mn = (a > b) ? b : a;
      do_op(a, b, lat, ia, ic, to);
      checks++;
      if (to || lat != exp_lat(a, b) || regs[5] !== exp_prod(a, b) || ia !== mx || ic !== mn) begin
        failures++;
        $display("FAIL rand%0d a=%0d b=%0d lat=%0d res=%0d cap=%0d/%0d need lat=%0d res=%0d cap=%0d/%0d",
                 i, a, b, lat, regs[5], ia, ic, exp_lat(a, b), exp_prod(a, b), mx, mn);
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (inv_viol != 0) begin
      failures++;
      $display("FAIL invariants got=%0d violations need=0", inv_viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'h0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_fsm.md
MULT_FSM -- requirements
Module: mult_fsm

Interface
REQ-001 SHALL provide parameter REG_A, default 6: datapath register index that holds the multiplicand.
REQ-002 SHALL provide parameter REG_CNT, default 7: register index that holds the loop count.
REQ-003 SHALL provide parameter REG_P, default 8: register index that holds the running product.
REQ-004 SHALL provide parameter REG_I, default 9: register index that holds the iteration counter.
REQ-005 SHALL provide parameter REG_OUT, default 5: register index that receives the final result.
REQ-006 SHALL have port clk, input, 1 bit: the single clock. All state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: request a multiply. Sampled only in IDLE.
REQ-009 SHALL have ports op_a and op_b, input, 16 bits each: unsigned operands. Sampled on the edge that accepts start.
REQ-010 SHALL have port Flags_out, input, 5 bits: datapath flags. Bit 4 = 1 when reg[Rdest_sel] < reg[Rsrc_sel] (unsigned) for a CMP in the same cycle.
REQ-011 SHALL have port wEnable, output, 16 bits: one-hot register write enable. All zero means no write.
REQ-012 SHALL have port Imm_in, output, 16 bits: immediate operand.
REQ-013 SHALL have port opcode, output, 8 bits: ALU opcode.
REQ-014 SHALL have ports Rdest_sel and Rsrc_sel, output, 4 bits each: register read selects.
REQ-015 SHALL have port Imm_sel, output, 1 bit: 0 selects Imm_in as operand B, 1 selects reg[Rsrc_sel].
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port done, output, 1 bit: single-cycle pulse in state DONE.

Function
REQ-018 Opcodes SHALL be:
  - NOP = 8'h00
  - ADDU = 8'b0000_0110
  - ADDUI = 8'b0110_0000
  - CMP = 8'b0000_1011
  - MOVI = 8'b1101_0000 (result = Imm_in)
REQ-019 Operand semantics: ADDUI result = reg[Rdest_sel] + Imm_in; ADDU result = reg[Rdest_sel] + reg[Rsrc_sel]; the result is written to the register selected by wEnable.
REQ-020 Default outputs in every state not listed below SHALL be: wEnable=0, Imm_in=0, opcode=NOP, Rdest_sel=0, Rsrc_sel=0, Imm_sel=1.
REQ-021 Outputs SHALL be combinational decodes of the present state and the captured operands only. start and op_a/op_b SHALL never drive outputs directly.
REQ-022 Capture rule: on accept, mult_q = max(op_a, op_b) and cnt_q = min(op_a, op_b). Equal operands: mult_q = op_a.
REQ-023 States and sequence:
  - IDLE -(start)-> LOAD_A -> LOAD_C -> CLR_P -> CLR_I -> CHECK
  - CHECK -> ADD if Flags_out[4]=1, else -> WRITE_OUT
  - ADD -> INC -> CHECK
  - WRITE_OUT -> DONE -> IDLE
  - Any unused encoding -> IDLE
REQ-024 LOAD_A: MOVI, Imm_in=mult_q, Imm_sel=0, wEnable bit REG_A.
REQ-025 LOAD_C: MOVI, Imm_in=cnt_q, Imm_sel=0, wEnable bit REG_CNT.
REQ-026 CLR_P: MOVI, Imm_in=0, Imm_sel=0, wEnable bit REG_P.
REQ-027 CLR_I: MOVI, Imm_in=0, Imm_sel=0, wEnable bit REG_I.
REQ-028 CHECK: CMP, Rdest_sel=REG_I, Rsrc_sel=REG_CNT, Imm_sel=1, wEnable=0.
REQ-029 ADD: ADDU, Rdest_sel=REG_P, Rsrc_sel=REG_A, Imm_sel=1, wEnable bit REG_P.
REQ-030 INC: ADDUI, Rdest_sel=REG_I, Imm_in=1, Imm_sel=0, wEnable bit REG_I.
REQ-031 WRITE_OUT: ADDUI, Rdest_sel=REG_P, Imm_in=0, Imm_sel=0, wEnable bit REG_OUT.
REQ-032 Latency: with start accepted at edge k, DONE SHALL occupy cycle k+7+3*cnt_q.
REQ-033 Arithmetic SHALL be 16-bit unsigned; the product wraps modulo 2^16. Overflow is not flagged.
REQ-034 cnt_q=0 SHALL take the first CHECK straight to WRITE_OUT; result = 0.
REQ-035 start while busy=1 SHALL be ignored. Captured operands SHALL not change until the next accept.
REQ-036 start held high through DONE SHALL begin a new operation only after IDLE is re-entered. There SHALL be a minimum of one IDLE cycle between operations.
REQ-037 At most one wEnable bit SHALL be high in any cycle.

Reset
REQ-038 reset=1 at a rising edge SHALL force IDLE and clear mult_q and cnt_q to 0. This applies in any state and takes priority over start.
REQ-039 During and after reset, outputs SHALL be the REQ-020 defaults with busy=0 and done=0. No register write SHALL follow reset until a new start.
REQ-040 Reset mid-operation SHALL abandon the operation without a WRITE_OUT or a done pulse.

Verification
REQ-041 Bench SHALL cover each of the following directed scenarios:
  - op_a=3, op_b=4 -> cnt_q=3, mult_q=4; r5=12; done at k+16.
  - op_a=0, op_b=5 -> cnt_q=0; CHECK goes directly to WRITE_OUT; r5=0; done at k+7.
  - op_a=300, op_b=300 -> r5=24464 (wrap); done at k+907.
  - start re-pulsed during ADD with op_a=9, op_b=9 -> ignored; original result unaffected; busy stays high.
  - reset asserted in the second INC -> next cycle IDLE with all outputs at defaults; no write to REG_OUT; done never pulses.
  - Every cycle of every test -> popcount(wEnable) <= 1; busy=0 exactly when in IDLE.
